// File: rtl/coincidence_gate_counter.sv
// Two-channel rising-edge and coincidence counter over a programmable gate period.
// Each completed gate's counts are latched for readout through a valid/ack handshake.
module coincidence_gate_counter #(
    parameter int COUNT_W  = 32,
    parameter int WINDOW_W = 8,
    parameter int GATE_W   = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                SIGNAL_LINE_1,
    input  logic                SIGNAL_LINE_2,
    input  logic                enable,
    input  logic [WINDOW_W-1:0] window,
    input  logic [GATE_W-1:0]   gate_period,
    output logic [COUNT_W-1:0]  count_ch1,
    output logic [COUNT_W-1:0]  count_ch2,
    output logic [COUNT_W-1:0]  count_coinc,
    output logic                snap_valid,
    input  logic                snap_ack,
    output logic                snap_missed
);

    localparam logic [COUNT_W-1:0]  COUNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0]  COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [WINDOW_W-1:0] WIN_ONE   = {{(WINDOW_W-1){1'b0}}, 1'b1};
    localparam logic [GATE_W-1:0]   GATE_ONE  = {{(GATE_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN1 = 2'd1,
        ST_OPEN2 = 2'd2
    } state_t;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v, input logic inc);
        return (inc && (v != COUNT_MAX)) ? (v + COUNT_ONE) : v;
    endfunction

    logic [1:0]          meta_q, meta_d, sync_q, sync_d, prev_q, prev_d, edge_q, edge_d;
    state_t              state_q, state_d;
    logic [WINDOW_W-1:0] wtimer_q, wtimer_d;
    logic [GATE_W-1:0]   gtimer_q, gtimer_d, period_q, period_d;
    logic [COUNT_W-1:0]  live1_q, live1_d, live2_q, live2_d, livec_q, livec_d;
    logic [COUNT_W-1:0]  cnt1_q, cnt1_d, cnt2_q, cnt2_d, cntc_q, cntc_d;
    logic                valid_q, valid_d, missed_q, missed_d;
    logic                e1, e2, coinc_hit, gate_run, terminal;
    logic [GATE_W-1:0]   period_eff;
    logic [COUNT_W-1:0]  next1, next2, nextc;

    // Two-flop synchroniser plus registered rising-edge pulse per channel.
    always_comb begin
        meta_d = {SIGNAL_LINE_2, SIGNAL_LINE_1};
        sync_d = meta_q;
        prev_d = sync_q;
        edge_d = sync_q & ~prev_q;
    end

    assign e1 = edge_q[0];
    assign e2 = edge_q[1];

    // Coincidence FSM: next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (e1 && e2)       state_d = ST_IDLE;
                else if (e1)        state_d = ST_OPEN1;
                else if (e2)        state_d = ST_OPEN2;
                else                state_d = ST_IDLE;
            end
            ST_OPEN1: begin
                if (e2)                     state_d = ST_IDLE;
                else if (e1)                state_d = ST_OPEN1;
                else if (wtimer_q == window) state_d = ST_IDLE;
                else                        state_d = ST_OPEN1;
            end
            ST_OPEN2: begin
                if (e1)                     state_d = ST_IDLE;
                else if (e2)                state_d = ST_OPEN2;
                else if (wtimer_q == window) state_d = ST_IDLE;
                else                        state_d = ST_OPEN2;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Coincidence FSM: hit pulse and window timer.
    always_comb begin
        coinc_hit = 1'b0;
        wtimer_d  = wtimer_q;
        case (state_q)
            ST_IDLE: begin
                if (e1 && e2)     coinc_hit = 1'b1;
                else if (e1 || e2) wtimer_d = '0;
                else              wtimer_d = wtimer_q;
            end
            ST_OPEN1, ST_OPEN2: begin
                if ((state_q == ST_OPEN1) ? e2 : e1) begin
                    coinc_hit = 1'b1;
                    wtimer_d  = '0;
                end else if ((state_q == ST_OPEN1) ? e1 : e2) begin
                    wtimer_d = '0;
                end else if (wtimer_q == window) begin
                    wtimer_d = '0;
                end else begin
                    wtimer_d = wtimer_q + WIN_ONE;
                end
            end
            default: begin
                coinc_hit = 1'b0;
                wtimer_d  = '0;
            end
        endcase
        if (!enable) begin
            coinc_hit = 1'b0;
            wtimer_d  = '0;
        end else begin
            coinc_hit = coinc_hit;
        end
    end

    // Gate timer, live counters and snapshot/handshake.
    always_comb begin
        period_eff = (gtimer_q == '0) ? gate_period : period_q;
        period_d   = period_eff;
        gate_run   = enable && (gate_period != '0);
        terminal   = gate_run && (gtimer_q == (period_eff - GATE_ONE));
        next1      = sat_inc(live1_q, e1);
        next2      = sat_inc(live2_q, e2);
        nextc      = sat_inc(livec_q, coinc_hit);
        cnt1_d     = cnt1_q;
        cnt2_d     = cnt2_q;
        cntc_d     = cntc_q;
        valid_d    = valid_q;
        missed_d   = missed_q;

        if (!enable)       gtimer_d = '0;
        else if (!gate_run) gtimer_d = gtimer_q;
        else if (terminal) gtimer_d = '0;
        else               gtimer_d = gtimer_q + GATE_ONE;

        if (!enable || terminal) begin
            live1_d = '0;
            live2_d = '0;
            livec_d = '0;
        end else begin
            live1_d = next1;
            live2_d = next2;
            livec_d = nextc;
        end

        // A gate ending while the previous snapshot is still unread is dropped.
        if (terminal) begin
            if (!valid_q || snap_ack) begin
                cnt1_d  = next1;
                cnt2_d  = next2;
                cntc_d  = nextc;
                valid_d = 1'b1;
            end else begin
                missed_d = 1'b1;
            end
        end else if (snap_ack && valid_q) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta_q   <= 2'b00;
            sync_q   <= 2'b00;
            prev_q   <= 2'b00;
            edge_q   <= 2'b00;
            state_q  <= ST_IDLE;
            wtimer_q <= '0;
            gtimer_q <= '0;
            period_q <= '0;
            live1_q  <= '0;
            live2_q  <= '0;
            livec_q  <= '0;
            cnt1_q   <= '0;
            cnt2_q   <= '0;
            cntc_q   <= '0;
            valid_q  <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            edge_q   <= edge_d;
            state_q  <= state_d;
            wtimer_q <= wtimer_d;
            gtimer_q <= gtimer_d;
            period_q <= period_d;
            live1_q  <= live1_d;
            live2_q  <= live2_d;
            livec_q  <= livec_d;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            cntc_q   <= cntc_d;
            valid_q  <= valid_d;
            missed_q <= missed_d;
        end
    end

    assign count_ch1   = cnt1_q;
    assign count_ch2   = cnt2_q;
    assign count_coinc = cntc_q;
    assign snap_valid  = valid_q;
    assign snap_missed = missed_q;

endmodule

// File: tb/tb_coincidence_gate_counter.sv
// Bench for coincidence_gate_counter: directed gate scenarios plus randomized traffic,
// all outputs compared every cycle against an event/timestamp reference model.
module tb_coincidence_gate_counter;

    logic        clk = 1'b0;
    logic        rst, l1, l2, en, ack;
    logic [7:0]  win;
    logic [31:0] gp;
    logic [31:0] ch1, ch2, cc;
    logic        sv, ms;
    logic [3:0]  s_ch1, s_ch2, s_cc;
    logic        s_sv, s_ms;

    int n_checks = 0;
    int n_errors = 0;

    coincidence_gate_counter dut (
        .CLK(clk), .RST(rst), .SIGNAL_LINE_1(l1), .SIGNAL_LINE_2(l2), .enable(en),
        .window(win), .gate_period(gp), .count_ch1(ch1), .count_ch2(ch2),
        .count_coinc(cc), .snap_valid(sv), .snap_ack(ack), .snap_missed(ms)
    );

    coincidence_gate_counter #(.COUNT_W(4)) dut_small (
        .CLK(clk), .RST(rst), .SIGNAL_LINE_1(l1), .SIGNAL_LINE_2(l2), .enable(en),
        .window(win), .gate_period(gp), .count_ch1(s_ch1), .count_ch2(s_ch2),
        .count_coinc(s_cc), .snap_valid(s_sv), .snap_ack(ack), .snap_missed(s_ms)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: line samples delayed to edge events, pending edge with timestamp.
    logic [3:0]  h1, h2;
    int unsigned m_c1, m_c2, m_cc, m_o1, m_o2, m_oc, m_el, m_per;
    bit          m_sv, m_ms;
    int          m_pend;
    longint      m_cyc, m_topen;

    function automatic int unsigned sat_add(input int unsigned v, input bit inc);
        return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    task automatic model_step();
        bit ev1, ev2, hit, term;
        m_cyc++;
        if (rst) begin
            h1 = 4'd0; h2 = 4'd0;
            m_c1 = 0; m_c2 = 0; m_cc = 0; m_o1 = 0; m_o2 = 0; m_oc = 0;
            m_el = 0; m_per = 0; m_sv = 1'b0; m_ms = 1'b0; m_pend = 0;
            return;
        end
        ev1 = h1[2] & ~h1[3];
        ev2 = h2[2] & ~h2[3];
        h1 = {h1[2:0], l1};
        h2 = {h2[2:0], l2};
        term = 1'b0;
        if (!en) begin
            m_c1 = 0; m_c2 = 0; m_cc = 0; m_pend = 0; m_el = 0;
        end else begin
            hit = 1'b0;
            if (m_pend != 0 && (m_cyc - m_topen) > longint'(win) + 1) m_pend = 0;
            if (ev1 && ev2) begin
                hit = 1'b1; m_pend = 0;
            end else if (ev1) begin
                if (m_pend == 2) begin hit = 1'b1; m_pend = 0; end
                else begin m_pend = 1; m_topen = m_cyc; end
            end else if (ev2) begin
                if (m_pend == 1) begin hit = 1'b1; m_pend = 0; end
                else begin m_pend = 2; m_topen = m_cyc; end
            end
            m_c1 = sat_add(m_c1, ev1);
            m_c2 = sat_add(m_c2, ev2);
            m_cc = sat_add(m_cc, hit);
            if (gp != 32'd0) begin
                if (m_el == 0) m_per = gp;
                if (m_el == m_per - 1) begin term = 1'b1; m_el = 0; end
                else m_el++;
            end
        end
        if (term) begin
            if (!m_sv || ack) begin
                m_o1 = m_c1; m_o2 = m_c2; m_oc = m_cc; m_sv = 1'b1;
            end else begin
                m_ms = 1'b1;
            end
            m_c1 = 0; m_c2 = 0; m_cc = 0;
        end else if (ack && m_sv) begin
            m_sv = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("ch1", ch1, m_o1);
        check_eq("ch2", ch2, m_o2);
        check_eq("coinc", cc, m_oc);
        check_eq("valid", {31'd0, sv}, {31'd0, m_sv});
        check_eq("missed", {31'd0, ms}, {31'd0, m_ms});
    endtask

    bit pat1 [0:255];
    bit pat2 [0:255];

    task automatic clear_pat();
        for (int i = 0; i < 256; i++) begin pat1[i] = 1'b0; pat2[i] = 1'b0; end
    endtask

    task automatic pulse(input int ch, input int t, input int len);
        for (int i = t; i < t + len; i++) begin
            if (ch == 1) pat1[i] = 1'b1;
            else         pat2[i] = 1'b1;
        end
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            l1 = pat1[i]; l2 = pat2[i];
            tick();
        end
        l1 = 1'b0; l2 = 1'b0;
    endtask

    task automatic start_gate(input logic [7:0] w, input logic [31:0] p);
        en = 1'b0;
        tick();
        win = w; gp = p; en = 1'b1;
        clear_pat();
    endtask

    task automatic ack_once(input string tag);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_eq(tag, {31'd0, sv}, 32'd0);
    endtask

    task automatic check_snap(input string tag, input int e1, input int e2, input int ec);
        check_eq({tag, "_valid"}, {31'd0, sv}, 32'd1);
        check_eq({tag, "_ch1"}, ch1, e1);
        check_eq({tag, "_ch2"}, ch2, e2);
        check_eq({tag, "_coinc"}, cc, ec);
    endtask

    initial begin
        rst = 1'b1; l1 = 1'b0; l2 = 1'b0; en = 1'b0; ack = 1'b0; win = 8'd4; gp = 32'd100;
        m_cyc = 0; m_topen = 0;
        tick();
        check_eq("rst_ch1", ch1, 32'd0);
        check_eq("rst_valid", {31'd0, sv}, 32'd0);
        check_eq("rst_small_ch1", {28'd0, s_ch1}, 32'd0);
        rst = 1'b0;

        start_gate(8'd4, 32'd100);
        pulse(1, 10, 3); pulse(2, 13, 3);
        play(100);
        check_snap("t1", 1, 1, 1);
        ack_once("t1_ack");

        start_gate(8'd4, 32'd100);
        pulse(1, 10, 3); pulse(2, 20, 3);
        play(100);
        check_snap("t2", 1, 1, 0);
        ack_once("t2_ack");

        start_gate(8'd0, 32'd100);
        for (int i = 0; i < 5; i++) begin pulse(1, 10 + 10 * i, 3); pulse(2, 10 + 10 * i, 3); end
        play(100);
        check_snap("t3", 5, 5, 5);
        ack_once("t3_ack");

        start_gate(8'd4, 32'd100);
        pulse(1, 10, 1); pulse(1, 12, 1); pulse(2, 15, 3);
        play(100);
        check_snap("t4", 2, 1, 1);
        ack_once("t4_ack");

        start_gate(8'd4, 32'd100);
        pulse(1, 10, 3); pulse(2, 13, 3);
        play(100);
        check_snap("t5a", 1, 1, 1);
        clear_pat();
        pulse(1, 20, 1); pulse(1, 30, 1);
        play(100);
        check_snap("t5b", 1, 1, 1);
        check_eq("t5b_missed", {31'd0, ms}, 32'd1);
        ack_once("t5_ack");
        clear_pat();
        pulse(2, 10, 2); pulse(2, 20, 2); pulse(2, 30, 2);
        play(99);
        check_snap("t5c", 0, 3, 0);
        ack_once("t5c_ack");

        start_gate(8'd4, 32'd100);
        for (int i = 0; i < 20; i++) pulse(1, 10 + 4 * i, 1);
        play(100);
        check_snap("t6", 20, 0, 0);
        check_eq("t6_small_ch1", {28'd0, s_ch1}, 32'd15);
        check_eq("t6_small_valid", {31'd0, s_sv}, 32'd1);
        ack_once("t6_ack");
        play(40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_rst_ch1", ch1, 32'd0);
        check_eq("t6_rst_missed", {31'd0, ms}, 32'd0);
        check_eq("t6_rst_small_ch1", {28'd0, s_ch1}, 32'd0);
        check_eq("t6_rst_small_valid", {31'd0, s_sv}, 32'd0);

        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 2) == 0) begin rst = 1'b1; tick(); rst = 1'b0; end
            en = 1'b0;
            tick();
            win = 8'($urandom_range(0, 6));
            gp  = 32'($urandom_range(0, 60));
            en  = 1'b1;
            for (int c = 0; c < 300; c++) begin
                l1  = ($urandom_range(0, 3) == 0);
                l2  = ($urandom_range(0, 3) == 0);
                ack = ($urandom_range(0, 7) == 0);
                en  = ($urandom_range(0, 99) != 0);
                tick();
            end
            ack = 1'b0; l1 = 1'b0; l2 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
